// File: rtl/agc_pwr_loop.sv
// AGC core: windowed mean I/Q power estimate driving a first-order PWM gain loop.
// Latency: sample at t -> estimate/rdy at t+2 -> pwm_ctrl at t+3 -> pwm_out after next PWM wrap.
// Backpressure: none; data_vld gaps only stall the window count, one sample per cycle accepted.
//
// Ports: clk/reset (sync, active-high); data_i_in/data_q_in/data_vld sample input;
// agc_en, agc_fix, pwm_fix_val, pwr_est_prd, pwr_ref, loop_step, lock_tol control;
// pwr_est_val/pwr_est_rdy estimate output; pwm_ctrl, pwm_out, agc_lock loop outputs.
// Optional lock detector compiled in with macro AGC_LOCK_DET_EN (otherwise agc_lock = 0).
module agc_pwr_loop #(
    parameter int DW    = 10,
    parameter int PWM_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DW-1:0]      data_i_in,
    input  logic [DW-1:0]      data_q_in,
    input  logic               data_vld,
    input  logic               agc_en,
    input  logic               agc_fix,
    input  logic [PWM_W-1:0]   pwm_fix_val,
    input  logic [1:0]         pwr_est_prd,
    input  logic [2*DW-1:0]    pwr_ref,
    input  logic [3:0]         loop_step,
    input  logic [2*DW-1:0]    lock_tol,
    output logic [2*DW-1:0]    pwr_est_val,
    output logic               pwr_est_rdy,
    output logic [PWM_W-1:0]   pwm_ctrl,
    output logic               pwm_out,
    output logic               agc_lock
);

    localparam int PW = 2 * DW;
    localparam int AW = PW + 14;
    localparam int CW = 14;
    // Loop arithmetic width: wide enough for err (PW+1) and pwm_ctrl plus delta without wrap.
    localparam int SW = ((PW + 1 > PWM_W + 1) ? PW + 1 : PWM_W + 1) + 1;
    localparam logic [PWM_W-1:0] MID = {1'b1, {(PWM_W-1){1'b0}}};

    // ---------------- squarer (S1) ----------------
    logic signed [PW-1:0] si_x, sq_x, sq_i, sq_q;
    logic [PW-1:0]        p_next, s1_p;
    logic                 s1_vld;

    assign si_x   = PW'($signed(data_i_in));
    assign sq_x   = PW'($signed(data_q_in));
    assign sq_i   = si_x * si_x;
    assign sq_q   = sq_x * sq_x;
    assign p_next = $unsigned(sq_i) + $unsigned(sq_q);

    // ---------------- accumulator / window ----------------
    logic [AW-1:0] acc, acc_sum;
    logic [CW-1:0] cnt, n_last;
    logic [1:0]    prd_lat, prd_cur;
    logic [4:0]    shamt;
    logic [PW-1:0] est_next;

    // The window length is taken live while the window is empty, then frozen.
    assign prd_cur  = (cnt == '0) ? pwr_est_prd : prd_lat;
    assign shamt    = 5'd8 + {2'b00, prd_cur, 1'b0};
    assign n_last   = CW'((15'd1 << shamt) - 15'd1);
    assign acc_sum  = acc + AW'(s1_p);
    assign est_next = PW'(acc_sum >> shamt);

    // ---------------- loop filter ----------------
    logic signed [SW-1:0] err_x, delta_x, sum_x;
    logic [PWM_W-1:0]     ctrl_next;

    assign err_x   = $signed({{(SW-PW){1'b0}}, pwr_ref}) - $signed({{(SW-PW){1'b0}}, pwr_est_val});
    assign delta_x = err_x >>> loop_step;
    assign sum_x   = $signed({{(SW-PWM_W){1'b0}}, pwm_ctrl}) + delta_x;

    always_comb begin
        ctrl_next = sum_x[PWM_W-1:0];
        if (sum_x < 0)
            ctrl_next = '0;
        else if (sum_x > $signed({{(SW-PWM_W){1'b0}}, {PWM_W{1'b1}}}))
            ctrl_next = '1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_p        <= '0;
            s1_vld      <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            prd_lat     <= '0;
            pwr_est_val <= '0;
            pwr_est_rdy <= 1'b0;
            pwm_ctrl    <= MID;
        end else begin
            s1_p        <= p_next;
            s1_vld      <= data_vld && agc_en;
            pwr_est_rdy <= 1'b0;
            if (!agc_en) begin
                acc <= '0;
                cnt <= '0;
            end else if (s1_vld) begin
                if (cnt == '0)
                    prd_lat <= pwr_est_prd;
                if (cnt == n_last) begin
                    pwr_est_val <= est_next;
                    pwr_est_rdy <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CW'(1);
                end
            end
            // Fixed gain wins; the loop only moves on the cycle after a fresh estimate.
            if (agc_fix)
                pwm_ctrl <= pwm_fix_val;
            else if (pwr_est_rdy && agc_en)
                pwm_ctrl <= ctrl_next;
        end
    end

    // ---------------- PWM ----------------
    logic [PWM_W-1:0] pwm_cnt, duty;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty    <= MID;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            // Duty only changes at the period boundary so no period is ever split.
            if (pwm_cnt == '1)
                duty <= pwm_ctrl;
            pwm_out <= (pwm_cnt < duty);
        end
    end

    // ---------------- lock detector ----------------
`ifdef AGC_LOCK_DET_EN
    logic [1:0]           lock_cnt;
    logic signed [SW-1:0] abs_err;
    logic                 in_tol;

    assign abs_err = (err_x < 0) ? -err_x : err_x;
    assign in_tol  = (abs_err <= $signed({{(SW-PW){1'b0}}, lock_tol}));

    // lock_cnt counts in-tolerance estimates already seen (0..3); the 4th sets the lock.
    always_ff @(posedge clk) begin
        if (reset || !agc_en || agc_fix) begin
            lock_cnt <= '0;
            agc_lock <= 1'b0;
        end else if (pwr_est_rdy) begin
            if (in_tol) begin
                if (lock_cnt == 2'd3)
                    agc_lock <= 1'b1;
                else
                    lock_cnt <= lock_cnt + 2'd1;
            end else begin
                lock_cnt <= '0;
                agc_lock <= 1'b0;
            end
        end
    end
`else
    logic unused_lock_tol;
    assign unused_lock_tol = ^lock_tol;
    assign agc_lock        = 1'b0;
`endif

endmodule

// File: tb/tb_agc_pwr_loop.sv
// Self-checking bench for agc_pwr_loop: drives sample windows and compares against
// an arithmetic model of the estimate, the saturating loop and the PWM duty.
// Build with or without AGC_LOCK_DET_EN; the lock expectation follows the macro.
`timescale 1ns/1ps
module tb_agc_pwr_loop;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  data_i_in = '0;
    logic [9:0]  data_q_in = '0;
    logic        data_vld = 1'b0;
    logic        agc_en = 1'b1;
    logic        agc_fix = 1'b0;
    logic [9:0]  pwm_fix_val = '0;
    logic [1:0]  pwr_est_prd = '0;
    logic [19:0] pwr_ref = '0;
    logic [3:0]  loop_step = '0;
    logic [19:0] lock_tol = 20'd16;
    logic [19:0] pwr_est_val;
    logic        pwr_est_rdy;
    logic [9:0]  pwm_ctrl;
    logic        pwm_out;
    logic        agc_lock;

    agc_pwr_loop #(.DW(10), .PWM_W(10)) dut (
        .clk(clk), .reset(reset),
        .data_i_in(data_i_in), .data_q_in(data_q_in), .data_vld(data_vld),
        .agc_en(agc_en), .agc_fix(agc_fix), .pwm_fix_val(pwm_fix_val),
        .pwr_est_prd(pwr_est_prd), .pwr_ref(pwr_ref), .loop_step(loop_step),
        .lock_tol(lock_tol), .pwr_est_val(pwr_est_val), .pwr_est_rdy(pwr_est_rdy),
        .pwm_ctrl(pwm_ctrl), .pwm_out(pwm_out), .agc_lock(agc_lock)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_ctrl = 512;
    int lock_run = 0;
    int last_est = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_ctrl(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic int exp_lock();
`ifdef AGC_LOCK_DET_EN
        return (lock_run >= 4) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // One full estimation window. gap<0 alternates valid/idle, else gap is idle percentage.
    task automatic run_window(input int prd, input int gap, input bit rnd,
                              input int fi, input int fq, input string nm);
        int n, got, early, step_i, vi, vq, err, aerr;
        longint sum;
        bit take;
        n = 1 << (8 + 2 * prd);
        sum = 0; got = 0; early = 0; step_i = 0;
        pwr_est_prd = 2'(prd);
        while (got < n) begin
            take = (gap < 0) ? (step_i % 2 == 0) : (int'($urandom_range(0, 99)) >= gap);
            if (take) begin
                vi = rnd ? int'($urandom_range(0, 1023)) - 512 : fi;
                vq = rnd ? int'($urandom_range(0, 1023)) - 512 : fq;
                data_i_in = 10'(vi);
                data_q_in = 10'(vq);
                data_vld  = 1'b1;
                sum += longint'(vi * vi + vq * vq);
                got++;
                // Window length must stay frozen once the window has started.
                if (got == 3) pwr_est_prd = 2'($urandom_range(0, 3));
            end else begin
                data_vld  = 1'b0;
                data_i_in = 10'($urandom);
                data_q_in = 10'($urandom);
            end
            step_i++;
            tick();
            if (pwr_est_rdy) early++;
        end
        data_vld = 1'b0;
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL %s early_rdy got %0d want 0", nm, early);
        end
        tick();
        last_est = int'(sum >> (8 + 2 * prd));
        checks++;
        if (pwr_est_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s rdy_latency got %b want 1", nm, pwr_est_rdy);
        end
        checks++;
        if (pwr_est_val !== 20'(last_est)) begin
            errors++;
            $display("FAIL %s est_val got %0d want %0d", nm, pwr_est_val, last_est);
        end
        err  = int'(pwr_ref) - last_est;
        aerr = (err < 0) ? -err : err;
        if (agc_fix) begin
            model_ctrl = int'(pwm_fix_val);
            lock_run = 0;
        end else begin
            model_ctrl = sat_ctrl(model_ctrl + (err >>> int'(loop_step)));
            lock_run = (aerr <= int'(lock_tol)) ? lock_run + 1 : 0;
        end
        tick();
        checks++;
        if (pwr_est_rdy !== 1'b0 || pwm_ctrl !== 10'(model_ctrl)) begin
            errors++;
            $display("FAIL %s ctrl got %0d rdy %b want %0d rdy 0", nm, pwm_ctrl, pwr_est_rdy, model_ctrl);
        end
    endtask

    // Let any pending duty change take effect, then count highs over one period.
    task automatic count_high(output int h);
        h = 0;
        repeat (1100) tick();
        for (int k = 0; k < 1024; k++) begin
            tick();
            if (pwm_out) h++;
        end
    endtask

    task automatic test_reset();
        int h;
        reset = 1'b1;
        repeat (3) tick();
        model_ctrl = 512;
        lock_run = 0;
        checks++;
        if (pwm_ctrl !== 10'd512 || pwr_est_val !== 20'd0 || pwr_est_rdy !== 1'b0 ||
            pwm_out !== 1'b0 || agc_lock !== 1'b0) begin
            errors++;
            $display("FAIL reset got ctrl %0d est %0d rdy %b out %b lock %b want 512 0 0 0 0",
                     pwm_ctrl, pwr_est_val, pwr_est_rdy, pwm_out, agc_lock);
        end
        reset = 1'b0;
        count_high(h);
        checks++;
        if (h !== 512) begin
            errors++;
            $display("FAIL reset_duty got %0d want 512", h);
        end
    endtask

    task automatic test_estimate();
        pwr_ref = 20'd10000;
        loop_step = 4'd0;
        run_window(0, 0, 1'b0, 100, 0, "est_cont");
        run_window(0, -1, 1'b0, 100, 0, "est_toggle");
    endtask

    task automatic test_back_to_back();
        int pulses, bad;
        pulses = 0; bad = 0;
        pwr_ref = 20'd10000;
        pwr_est_prd = 2'd0;
        data_i_in = 10'd100;
        data_q_in = 10'd0;
        for (int j = 0; j < 770; j++) begin
            data_vld = (j < 768);
            tick();
            if (pwr_est_rdy) begin
                pulses++;
                if (j % 256 != 0 || j == 0 || pwr_est_val !== 20'd10000) bad++;
            end
        end
        data_vld = 1'b0;
        checks++;
        if (pulses !== 3 || bad !== 0) begin
            errors++;
            $display("FAIL back_to_back got %0d pulses %0d bad want 3 pulses 0 bad", pulses, bad);
        end
        checks++;
        if (pwm_ctrl !== 10'(model_ctrl)) begin
            errors++;
            $display("FAIL back_to_back_ctrl got %0d want %0d", pwm_ctrl, model_ctrl);
        end
    endtask

    task automatic test_loop_sat();
        int h;
        pwr_ref = 20'd12048;
        loop_step = 4'd2;
        run_window(0, 0, 1'b0, 100, 0, "sat_high");
        count_high(h);
        checks++;
        if (h !== 1023) begin
            errors++;
            $display("FAIL sat_high_duty got %0d want 1023", h);
        end
        pwr_ref = 20'd0;
        loop_step = 4'd0;
        run_window(0, 20, 1'b0, 100, 0, "sat_low");
        count_high(h);
        checks++;
        if (h !== 0) begin
            errors++;
            $display("FAIL sat_low_duty got %0d want 0", h);
        end
    endtask

    task automatic test_full_scale();
        pwr_ref = 20'd524288;
        loop_step = 4'd10;
        run_window(3, 0, 1'b0, -512, -512, "full_scale");
    endtask

    task automatic test_fix();
        int h;
        pwm_fix_val = 10'd100;
        agc_fix = 1'b1;
        tick();
        model_ctrl = 100;
        lock_run = 0;
        checks++;
        if (pwm_ctrl !== 10'd100) begin
            errors++;
            $display("FAIL fix_load got %0d want 100", pwm_ctrl);
        end
        count_high(h);
        checks++;
        if (h !== 100) begin
            errors++;
            $display("FAIL fix_duty got %0d want 100", h);
        end
        pwr_ref = 20'd0;
        loop_step = 4'd0;
        run_window(0, 30, 1'b0, 50, 50, "fix_est");
        agc_fix = 1'b0;
        pwr_ref = 20'd10040;
        loop_step = 4'd2;
        run_window(0, 0, 1'b0, 100, 0, "fix_release");
    endtask

    task automatic test_enable();
        int pulses;
        pulses = 0;
        agc_en = 1'b0;
        pwr_est_prd = 2'd0;
        for (int j = 0; j < 300; j++) begin
            data_vld  = 1'b1;
            data_i_in = 10'($urandom);
            data_q_in = 10'($urandom);
            tick();
            if (pwr_est_rdy) pulses++;
        end
        data_vld = 1'b0;
        checks++;
        if (pulses !== 0 || pwm_ctrl !== 10'(model_ctrl)) begin
            errors++;
            $display("FAIL disabled got %0d pulses ctrl %0d want 0 pulses ctrl %0d", pulses, pwm_ctrl, model_ctrl);
        end
        // Partial window, then disable: the next window must start empty.
        agc_en = 1'b1;
        data_i_in = 10'd300;
        data_q_in = 10'd0;
        data_vld = 1'b1;
        repeat (100) tick();
        data_vld = 1'b0;
        agc_en = 1'b0;
        repeat (3) tick();
        agc_en = 1'b1;
        lock_run = 0;
        run_window(0, 10, 1'b0, 100, 0, "reenable");
    endtask

    task automatic test_reset_mid();
        data_i_in = 10'd300;
        data_q_in = 10'd0;
        data_vld = 1'b1;
        pwr_est_prd = 2'd0;
        repeat (100) tick();
        reset = 1'b1;
        repeat (2) tick();
        data_vld = 1'b0;
        reset = 1'b0;
        model_ctrl = 512;
        lock_run = 0;
        checks++;
        if (pwm_ctrl !== 10'd512 || pwr_est_val !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid got ctrl %0d est %0d want 512 0", pwm_ctrl, pwr_est_val);
        end
        pwr_ref = 20'd9000;
        loop_step = 4'd3;
        run_window(0, 0, 1'b0, 100, 0, "reset_mid_win");
    endtask

    task automatic test_random();
        for (int w = 0; w < 4; w++) begin
            pwr_ref = 20'($urandom_range(0, 300000));
            loop_step = 4'($urandom_range(0, 15));
            run_window(int'($urandom_range(0, 1)), int'($urandom_range(0, 60)), 1'b1, 0, 0, "random");
        end
    endtask

    task automatic test_lock();
        agc_fix = 1'b1;
        pwm_fix_val = 10'd512;
        tick();
        agc_fix = 1'b0;
        model_ctrl = 512;
        lock_run = 0;
        lock_tol = 20'd16;
        pwr_ref = 20'd10000;
        loop_step = 4'd15;
        for (int k = 1; k <= 5; k++) begin
            run_window(0, 0, 1'b0, 100, 0, "lock_settle");
            checks++;
            if (agc_lock !== 1'(exp_lock())) begin
                errors++;
                $display("FAIL lock_est%0d got %b want %0d", k, agc_lock, exp_lock());
            end
        end
        run_window(0, 0, 1'b0, 200, 0, "lock_break");
        checks++;
        if (agc_lock !== 1'(exp_lock())) begin
            errors++;
            $display("FAIL lock_break got %b want %0d", agc_lock, exp_lock());
        end
    endtask

    initial begin
        test_reset();
        test_estimate();
        test_back_to_back();
        test_loop_sat();
        test_full_scale();
        test_fix();
        test_enable();
        test_reset_mid();
        test_random();
        test_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
